// File: rtl/gray_code_updown_decoder_if.sv
// Gray up/down decoder bus.
// Groups the sampled gray input, the sticky-error clear and every decoded
// output of the decoder.
//   master : the source/consumer side (drives sample_en, gray_in, clr_err)
//   slave  : the decoder side (drives bin_out, pos, dir, step_valid, err,
//            err_sticky)
interface gray_code_updown_decoder_if #(
  parameter int BIT   = 3,
  parameter int POS_W = 16
);
  logic             sample_en;
  logic [BIT-1:0]   gray_in;
  logic             clr_err;
  logic [BIT-1:0]   bin_out;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic             step_valid;
  logic             err;
  logic             err_sticky;

  modport master (
    output sample_en, gray_in, clr_err,
    input  bin_out, pos, dir, step_valid, err, err_sticky
  );

  modport slave (
    input  sample_en, gray_in, clr_err,
    output bin_out, pos, dir, step_valid, err, err_sticky
  );
endinterface

// File: rtl/gray_code_updown_decoder.sv
// Gray-coded up/down position decoder.
// Samples a BIT-wide gray code, converts it to binary and classifies each
// new sample as an up step, a down step, a hold or an illegal jump. A wide
// position count is accumulated from the narrow wrapping code.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decoder side of the bus: sample_en, gray_in, clr_err in;
//          bin_out, pos, dir, step_valid, err, err_sticky out
//
// state    | meaning
// ST_INIT  | no reference yet; the next sample only loads bin_out
// ST_TRACK | reference held in bin_out; each sample is classified against it
module gray_code_updown_decoder #(
  parameter int BIT   = 3,
  parameter int POS_W = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  gray_code_updown_decoder_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  localparam logic [BIT-1:0] D_UP = BIT'(1);
  localparam logic [BIT-1:0] D_DN = '1;

  state_t           state_q, state_nxt;
  logic [BIT-1:0]   bin_q, bin_nxt;
  logic [POS_W-1:0] pos_q, pos_nxt;
  logic             dir_q, dir_nxt;
  logic             sv_q, sv_nxt;
  logic             err_q, err_nxt;
  logic             sticky_q, sticky_nxt;
  logic [BIT-1:0]   bin_new;
  logic [BIT-1:0]   delta;

  function automatic logic [BIT-1:0] g2b(input logic [BIT-1:0] g);
    logic [BIT-1:0] b;
    b[BIT-1] = g[BIT-1];
    for (int i = BIT - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_new = g2b(bus.gray_in);
  // Modulo-2^BIT difference: code wrap in either direction lands on D_UP/D_DN.
  assign delta   = bin_new - bin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (bus.sample_en && state_q == ST_INIT) begin
      state_nxt = ST_TRACK;
    end
  end

  always_comb begin
    bin_nxt    = bin_q;
    pos_nxt    = pos_q;
    dir_nxt    = dir_q;
    sv_nxt     = 1'b0;
    err_nxt    = 1'b0;
    sticky_nxt = bus.clr_err ? 1'b0 : sticky_q;
    if (bus.sample_en) begin
      case (state_q)
        ST_INIT: begin
          bin_nxt = bin_new;
        end
        ST_TRACK: begin
          if (delta == D_UP) begin
            sv_nxt  = 1'b1;
            dir_nxt = 1'b1;
            pos_nxt = pos_q + POS_W'(1);
            bin_nxt = bin_new;
          end else if (delta == D_DN) begin
            sv_nxt  = 1'b1;
            dir_nxt = 1'b0;
            pos_nxt = pos_q - POS_W'(1);
            bin_nxt = bin_new;
          end else if (delta != '0) begin
            // Illegal jump: flag it and resync the reference to the new code.
            err_nxt    = 1'b1;
            sticky_nxt = 1'b1;
            bin_nxt    = bin_new;
          end
        end
        default: begin
          bin_nxt = bin_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      sv_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      bin_q    <= bin_nxt;
      pos_q    <= pos_nxt;
      dir_q    <= dir_nxt;
      sv_q     <= sv_nxt;
      err_q    <= err_nxt;
      sticky_q <= sticky_nxt;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.pos        = pos_q;
  assign bus.dir        = dir_q;
  assign bus.step_valid = sv_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_code_updown_decoder.sv
// Bench for gray_code_updown_decoder (BIT=3, POS_W=16): directed scenarios
// followed by random stimulus checked against a behavioural model.
module tb_gray_code_updown_decoder;

  localparam int BIT   = 3;
  localparam int POS_W = 16;
  localparam int NCODE = 1 << BIT;
  localparam int NPOS  = 1 << POS_W;

  logic clk;
  logic rst_n;

  gray_code_updown_decoder_if #(.BIT(BIT), .POS_W(POS_W)) bus ();

  gray_code_updown_decoder #(.BIT(BIT), .POS_W(POS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Behavioural model state
  bit m_have;
  int m_ref;
  int m_pos;
  bit m_dir;
  bit m_sv;
  bit m_err;
  bit m_sticky;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Decode by searching for the binary value whose gray encoding matches.
  function automatic int decode(input int g);
    for (int b = 0; b < NCODE; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic logic [BIT-1:0] encode(input int b);
    return BIT'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_have = 0; m_ref = 0; m_pos = 0; m_dir = 0;
    m_sv = 0; m_err = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit en, input int g, input bit clr);
    int nb;
    int d;
    m_sv  = 0;
    m_err = 0;
    if (en) begin
      nb = decode(g);
      if (!m_have) begin
        m_have = 1;
        m_ref  = nb;
      end else begin
        d = (nb - m_ref + NCODE) % NCODE;
        if (d == 1) begin
          m_sv = 1; m_dir = 1; m_pos = (m_pos + 1) % NPOS; m_ref = nb;
        end else if (d == NCODE - 1) begin
          m_sv = 1; m_dir = 0; m_pos = (m_pos + NPOS - 1) % NPOS; m_ref = nb;
        end else if (d != 0) begin
          m_err = 1; m_ref = nb;
        end
      end
    end
    if (m_err) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_bin"},    32'(bus.bin_out),    32'(m_ref));
    check_val({tag, "_pos"},    32'(bus.pos),        32'(m_pos));
    check_val({tag, "_dir"},    32'(bus.dir),        32'(m_dir));
    check_val({tag, "_sv"},     32'(bus.step_valid), 32'(m_sv));
    check_val({tag, "_err"},    32'(bus.err),        32'(m_err));
    check_val({tag, "_sticky"}, 32'(bus.err_sticky), 32'(m_sticky));
  endtask

  task automatic apply(input string tag, input bit en, input logic [BIT-1:0] g, input bit clr);
    @(negedge clk);
    bus.sample_en = en;
    bus.gray_in   = g;
    bus.clr_err   = clr;
    @(posedge clk);
    model_step(en, int'(g), clr);
    #1;
    compare_all(tag);
    bus.sample_en = 1'b0;
    bus.clr_err   = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    check_val({tag, "_pos0"}, 32'(bus.pos), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int kind;
    int off;
    int tgt;
    logic [BIT-1:0] seq_up [8];
    n_vec  = 0;
    n_miss = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.sample_en = 1'b0;
    bus.gray_in   = '0;
    bus.clr_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first sample sets the reference only
    apply("t1", 1'b1, 3'b000, 1'b0);
    check_val("t1_sv_none", 32'(bus.step_valid), 32'd0);

    // 2: full up cycle including the 7 -> 0 wrap
    seq_up = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    for (int i = 0; i < 8; i++) begin
      apply("t2", 1'b1, seq_up[i], 1'b0);
      check_val("t2_pulse", 32'(bus.step_valid), 32'd1);
    end
    check_val("t2_pos8", 32'(bus.pos), 32'd8);
    check_val("t2_dir", 32'(bus.dir), 32'd1);
    check_val("t2_bin0", 32'(bus.bin_out), 32'd0);

    // 3: down wrap 0 -> 7, position wraps below zero, then back up across 0xFFFF
    do_reset("t3_rst");
    apply("t3", 1'b1, 3'b000, 1'b0);
    apply("t3", 1'b1, 3'b100, 1'b0);
    check_val("t3_pos", 32'(bus.pos), 32'h0000_FFFF);
    check_val("t3_bin", 32'(bus.bin_out), 32'd7);
    check_val("t3_dir", 32'(bus.dir), 32'd0);
    apply("t3w", 1'b1, 3'b000, 1'b0);
    check_val("t3_posw", 32'(bus.pos), 32'd0);

    // 4: illegal jump resyncs, next step judged from the new value
    do_reset("t4_rst");
    apply("t4", 1'b1, 3'b000, 1'b0);
    apply("t4", 1'b1, 3'b011, 1'b0);
    check_val("t4_err", 32'(bus.err), 32'd1);
    check_val("t4_bin", 32'(bus.bin_out), 32'd2);
    check_val("t4_pos", 32'(bus.pos), 32'd0);
    apply("t4", 1'b1, 3'b010, 1'b0);
    check_val("t4_pos1", 32'(bus.pos), 32'd1);
    check_val("t4_errlo", 32'(bus.err), 32'd0);
    check_val("t4_stk", 32'(bus.err_sticky), 32'd1);

    // 5: hold, error beating clr_err, clr_err alone
    apply("t5h", 1'b1, 3'b010, 1'b0);
    check_val("t5_hold", 32'(bus.step_valid), 32'd0);
    apply("t5e", 1'b1, 3'b000, 1'b1);
    check_val("t5_stk1", 32'(bus.err_sticky), 32'd1);
    apply("t5c", 1'b0, 3'b000, 1'b1);
    check_val("t5_stk0", 32'(bus.err_sticky), 32'd0);

    // 6: reset mid-sequence, then re-reference
    apply("t6", 1'b1, 3'b001, 1'b0);
    apply("t6", 1'b1, 3'b011, 1'b0);
    do_reset("t6_rst");
    apply("t6r", 1'b1, 3'b001, 1'b0);
    check_val("t6_noref_sv", 32'(bus.step_valid), 32'd0);
    check_val("t6_bin", 32'(bus.bin_out), 32'd1);

    // Random mix of steps, holds, jumps, idle cycles and clears
    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        1, 2, 3: off = 1;
        4, 5, 6: off = NCODE - 1;
        7:       off = 0;
        default: off = $urandom_range(2, NCODE - 2);
      endcase
      tgt = (m_ref + off) % NCODE;
      apply("rnd", kind != 0, encode(tgt), $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
